// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared constants and client FSM encoding for the arbiter slice
// Rev 1.0
// ============================================================================
package arb_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_MAX_CYC = 4;

  localparam int CLIENT_ST_W = 2;
  typedef logic [CLIENT_ST_W-1:0] client_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arb_client_fifo.sv
`default_nettype none
// ============================================================================
// arb_client_fifo : synchronous FIFO with wrapping pointers and word count
// Rev 1.0
// ============================================================================
module arb_client_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_req_client.sv
`default_nettype none
// ============================================================================
// arb_req_client : buffered requester front end for the round-robin arbiter
// Rev 1.0
// ============================================================================
module arb_req_client
  import arb_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int DEPTH   = 8,
  parameter  int MAX_CYC = ARB_MAX_CYC,
  localparam int SW      = $clog2(MAX_CYC + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          req,
  input  logic          gnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] slice_cnt,
  output logic          preempt,
  output logic          gnt_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  logic          r_req;
  client_state_t r_state;
  client_state_t w_state_next;
  logic          w_preempt_set;
  logic          r_preempt;
  logic [SW-1:0] r_slice;
  logic          r_tail;
  logic          r_gnt_err;
  logic          w_err_set;

  assign w_push       = in_valid && !w_full;
  assign w_pop        = gnt && !w_empty;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  assign in_ready  = !w_full;
  assign out_valid = w_pop;
  assign req       = r_req;
  assign slice_cnt = r_slice;
  assign preempt   = r_preempt;
  assign gnt_err   = r_gnt_err;

  arb_client_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .head_data (out_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_state_next  = r_state;
    w_preempt_set = 1'b0;
    case (r_state)
      ST_IDLE: if (w_count_next != '0) w_state_next = ST_WAIT;
      ST_WAIT: if (gnt) w_state_next = ST_OWN;
      ST_OWN: begin
        if (!gnt) begin
          if (!w_empty) begin
            w_state_next  = ST_WAIT;
            w_preempt_set = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_preempt <= 1'b0;
      r_req     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_preempt <= w_preempt_set;
      r_req     <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slice <= '0;
    end else if (!gnt) begin
      r_slice <= '0;
    end else if (r_slice != SW'(MAX_CYC + 1)) begin
      r_slice <= r_slice + 1'b1;
    end
  end

  // One grant cycle without a request is the legal tail; a second in a row is not.
  assign w_err_set = gnt && ((r_slice == SW'(MAX_CYC)) || (!r_req && r_tail));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tail    <= 1'b0;
      r_gnt_err <= 1'b0;
    end else begin
      r_tail    <= gnt && !r_req;
      r_gnt_err <= r_gnt_err | w_err_set;
    end
  end

endmodule
`default_nettype wire

// File: doc/arb_req_client.md
# arb_req_client

Requester-side front end for the 4-way fixed-time-slice round-robin arbiter. One instance sits in front of each arbiter input. It buffers upstream words in a small FIFO and drives its `req` bit while data is pending. It drains one word per cycle while its `gnt` bit is high, tracks slice length and preemption, and flags grants that break the arbiter protocol.

## Interface
- `DW`, 8, data word width
- `DEPTH`, 8, FIFO depth in words; power of two, ≥2
- `MAX_CYC`, 4, arbiter slice length in cycles; must equal the arbiter's max cycle count

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream word present
- `in_data`  in  DW  upstream word
- `in_ready`  out  1  FIFO not full; push occurs when `in_valid && in_ready`
- `req`  out  1  request to arbiter (registered)
- `gnt`  in  1  this requester's grant bit from arbiter
- `out_valid`  out  1  word driven to shared resource this cycle
- `out_data`  out  DW  FIFO head word
- `slice_cnt`  out  $clog2(MAX_CYC+2)  consecutive granted cycles, saturating at MAX_CYC+1
- `preempt`  out  1  one-cycle pulse: grant was lost with data still queued
- `gnt_err`  out  1  sticky protocol-violation flag

## Operation
- Push: accepted when `in_valid && !full`. A push while full is ignored and the data is dropped; the source must honour `in_ready`.
- Pop: occurs when `gnt && count!=0`. `out_valid = gnt && count!=0` (combinational). `out_data` = head word whenever `count!=0`.
- Simultaneous push and pop: both occur and `count` is unchanged. A push to an empty FIFO is not visible as `out_valid` until the next cycle.
- `in_ready = (count != DEPTH)` and does not account for a same-cycle pop.
- `count_next` = count + push − pop. `req <= (count_next != 0)`.
- FSM (3 states, registered):
  - IDLE → WAIT when `count_next != 0`.
  - WAIT → OWN when `gnt`.
  - OWN with `!gnt`:
    - if `count != 0`: go to WAIT and set `preempt <= 1`.
    - otherwise: go to IDLE.
  - OWN with `gnt`: stay in OWN. This includes the legal tail cycle after the last pop.
- `preempt` is high only for the one cycle after the transition.
- `slice_cnt`: reset to 0 in any cycle with `!gnt`. Otherwise increments, saturating at MAX_CYC+1.
- `gnt_err` is set, and held until reset, when either:
  - `gnt` is high and `slice_cnt == MAX_CYC` (a fifth consecutive grant when MAX_CYC=4), or
  - `gnt && !req` holds for two consecutive cycles. A single such cycle is the legal tail.

## Timing
- Reset values: `req`=0, `count`=0, state IDLE, `slice_cnt`=0, `preempt`=0, `gnt_err`=0. Combinational outputs follow: `out_valid`=0, `in_ready`=1.
- Push-to-req latency: `req` rises 1 cycle after the first push edge.
- The arbiter's IDLE→Sx step adds 1 cycle, so the first `out_valid` comes 2 cycles after the push.
- After the final pop, `req` falls on the next edge. The arbiter still shows `gnt` for that one tail cycle, with `out_valid`=0.
- Full slice: exactly MAX_CYC words are popped per grant. If words remain, `req` stays high through preemption.
- Reset mid-operation: asserting `rst` low clears FIFO contents and all outputs immediately, with no edge required. `req` goes low asynchronously.

## Structure
- Shared package `arb_pkg` holds:
  - the client FSM state encoding (IDLE/WAIT/OWN),
  - the default slice constant `ARB_MAX_CYC = 4`, which the arbiter also uses,
  - the requester count (4).
- Sub-module `arb_client_fifo`: synchronous FIFO parameterised by DW/DEPTH. It has pointers with wrap, `count`, `full`/`empty`, and simultaneous push/pop. The top level holds the FSM, `req` register, slice counter and error logic.
- The bench instantiates 4 clients and the arbiter to test the closed loop. The directed tests below drive `gnt` from a model.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release → all outputs 0, `in_ready`=1. `gnt`=1 with `rst`=0 → `out_valid`=0.
- Short burst: push 0x11, 0x22, 0x33 on consecutive cycles; the model grants 1 cycle after `req` → `out_data` 0x11, 0x22, 0x33 on 3 consecutive valid cycles. `req` falls after the last pop, followed by one tail cycle with `out_valid`=0. `preempt` and `gnt_err` stay 0.
- Preemption: push 6 words, grant 4 cycles, drop for 3, then regrant → 4 words out, `preempt` pulses once, `req` stays 1, `slice_cnt` shows 1..4 then 0. The remaining 2 words come out in order after regrant.
- Full/wrap: push 9 words with `gnt`=0 → `in_ready` goes 0 after the 8th, and the 9th is not stored. Then grant, drain 4 (one full slice), push 4 more → pointers wrap, and all 12 stored words come out in FIFO order.
- Simultaneous push/pop at `count`=3 with `gnt`=1 → `count` stays 3 and no word is lost or duplicated.
- Protocol error: hold `gnt`=1 for 5 cycles with data queued → `gnt_err`=1 after the 5th edge, and it stays 1. Then pulse `rst` low while 2 words are queued → `count`=0, `req`=0 and `gnt_err`=0 immediately.
